// File: rtl/duck_pkg.sv
// Shared screen geometry, timing constants and motion-state encoding for the
// bird sprite, plus small pure helpers used by the motion and LFSR blocks.
package duck_pkg;

    localparam logic [7:0] SCREEN_W    = 8'd160;
    localparam logic [7:0] HITBOX_W    = 8'd14;
    localparam logic [7:0] HITBOX_H    = 8'd9;
    localparam logic [7:0] X_MAX       = SCREEN_W - HITBOX_W;
    localparam logic [7:0] GROUND_Y    = 8'd100;
    localparam logic [7:0] ROAM_TOP    = 8'd8;
    localparam logic [7:0] ROAM_BOTTOM = 8'd80;
    localparam logic [7:0] FALL_STEP   = 8'd2;
    localparam logic [7:0] SPAWN_WRAP  = 8'd128;
    localparam logic [4:0] HIT_TICKS   = 5'd16;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLY_IN = 3'd1,
        S_ROAM   = 3'd2,
        S_HIT    = 3'd3,
        S_FALL   = 3'd4,
        S_ESCAPE = 3'd5
    } motion_state_e;

    // Fold random values past the right edge back onto the screen.
    function automatic logic [7:0] spawn_x(input logic [7:0] rnd);
        if (rnd > X_MAX) begin
            return rnd - SPAWN_WRAP;
        end else begin
            return rnd;
        end
    endfunction

    // Fibonacci step for x^8 + x^6 + x^5 + x^4 + 1 (taps at bits 7,5,4,3).
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/bird_lfsr.sv
// Free-running 8-bit maximal-length LFSR used to pick spawn X and direction.
module bird_lfsr
    import duck_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next value; the all-zero lock-up state is steered back to the seed.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (lfsr_d == 8'd0) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = lfsr_d;
        end
    end

    // Advance once per clock; reset loads the fixed seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/bird_motion.sv
// Bird motion controller: spawn, fly-in, bouncing roam, hit/fall and escape.
module bird_motion
    import duck_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       isShot,
    input  logic       escape,
    output logic [7:0] XBird,
    output logic [7:0] YBird,
    output logic       fly,
    output logic       fall,
    output logic       visible,
    output logic       birdDown,
    output logic       birdGone
);

    motion_state_e state_q;
    logic [7:0]    x_q, y_q;
    logic          dir_x_q;      // 1 = moving right
    logic          dir_up_q;     // 1 = moving up (Y decreasing)
    logic [4:0]    hit_cnt_q;
    logic          bird_down_q, bird_gone_q;
    logic [7:0]    lfsr_value;

    logic [7:0]    roam_x_d, roam_y_d, fall_y_d;
    logic          roam_dir_x_d, roam_dir_up_d;

    bird_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr_value)
    );

    // One roam step: edges are tested before moving so a bounce never wraps.
    always_comb begin
        roam_x_d      = x_q;
        roam_dir_x_d  = dir_x_q;
        roam_y_d      = y_q;
        roam_dir_up_d = dir_up_q;
        if (dir_x_q) begin
            if (x_q >= X_MAX) roam_dir_x_d = 1'b0;
            else              roam_x_d     = x_q + 8'd1;
        end else begin
            if (x_q == 8'd0)  roam_dir_x_d = 1'b1;
            else              roam_x_d     = x_q - 8'd1;
        end
        if (dir_up_q) begin
            if (y_q <= ROAM_TOP)    roam_dir_up_d = 1'b0;
            else                    roam_y_d      = y_q - 8'd1;
        end else begin
            if (y_q >= ROAM_BOTTOM) roam_dir_up_d = 1'b1;
            else                    roam_y_d      = y_q + 8'd1;
        end
    end

    // Falling step saturates at the ground line.
    always_comb begin
        if (y_q >= (GROUND_Y - FALL_STEP)) begin
            fall_y_d = GROUND_Y;
        end else begin
            fall_y_d = y_q + FALL_STEP;
        end
    end

    // Motion state machine with position, direction, hit timer and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= 8'd0;
            y_q         <= GROUND_Y;
            dir_x_q     <= 1'b0;
            dir_up_q    <= 1'b1;
            hit_cnt_q   <= 5'd0;
            bird_down_q <= 1'b0;
            bird_gone_q <= 1'b0;
        end else begin
            bird_down_q <= 1'b0;
            bird_gone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_FLY_IN;
                        x_q      <= spawn_x(lfsr_value);
                        y_q      <= GROUND_Y;
                        dir_x_q  <= lfsr_value[0];
                        dir_up_q <= 1'b1;
                    end
                end
                S_FLY_IN: begin
                    if (escape) begin
                        state_q <= S_ESCAPE;
                    end else if (tick) begin
                        y_q <= y_q - 8'd1;
                        if ((y_q - 8'd1) <= ROAM_BOTTOM) state_q <= S_ROAM;
                    end
                end
                S_ROAM: begin
                    if (isShot) begin
                        state_q   <= S_HIT;
                        hit_cnt_q <= 5'd0;
                    end else if (escape) begin
                        state_q <= S_ESCAPE;
                    end else if (tick) begin
                        x_q      <= roam_x_d;
                        y_q      <= roam_y_d;
                        dir_x_q  <= roam_dir_x_d;
                        dir_up_q <= roam_dir_up_d;
                    end
                end
                S_HIT: begin
                    if (tick) begin
                        hit_cnt_q <= hit_cnt_q + 5'd1;
                        if ((hit_cnt_q + 5'd1) == HIT_TICKS) state_q <= S_FALL;
                    end
                end
                S_FALL: begin
                    if (tick) begin
                        y_q <= fall_y_d;
                        if (fall_y_d == GROUND_Y) begin
                            bird_down_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_ESCAPE: begin
                    if (tick) begin
                        if (y_q == 8'd0) begin
                            bird_gone_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            y_q <= y_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign XBird    = x_q;
    assign YBird    = y_q;
    assign birdDown = bird_down_q;
    assign birdGone = bird_gone_q;
    assign fly      = (state_q == S_FLY_IN) || (state_q == S_ESCAPE);
    assign fall     = (state_q == S_HIT) || (state_q == S_FALL);
    assign visible  = (state_q != S_IDLE);

endmodule

// File: tb/tb_bird_motion.sv
// Directed + randomized bench for bird_motion with a behavioural reference model.
module tb_bird_motion;

    logic       clk = 1'b0;
    logic       reset, start, tick, isShot, escape;
    logic [7:0] XBird, YBird;
    logic       fly, fall, visible, birdDown, birdGone;

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain integers, modes named by constants).
    localparam int M_IDLE = 0, M_FLY = 1, M_ROAM = 2, M_HIT = 3, M_FALL = 4, M_ESC = 5;
    int         m_mode, m_x, m_y, m_dx, m_up, m_cnt, m_down, m_gone;
    logic [7:0] m_lfsr;

    bird_motion dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tick     (tick),
        .isShot   (isShot),
        .escape   (escape),
        .XBird    (XBird),
        .YBird    (YBird),
        .fly      (fly),
        .fall     (fall),
        .visible  (visible),
        .birdDown (birdDown),
        .birdGone (birdGone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the behavioural rules to the model.
    task automatic model_step();
        int nx, ny;
        logic fb;
        if (reset) begin
            m_mode = M_IDLE; m_x = 0; m_y = 100; m_dx = 0; m_up = 1; m_cnt = 0;
            m_lfsr = 8'hA5; m_down = 0; m_gone = 0;
            return;
        end
        m_down = 0;
        m_gone = 0;
        if (m_mode == M_IDLE) begin
            if (start) begin
                m_x    = (int'(m_lfsr) > 146) ? int'(m_lfsr) - 128 : int'(m_lfsr);
                m_y    = 100;
                m_dx   = int'(m_lfsr[0]);
                m_up   = 1;
                m_mode = M_FLY;
            end
        end else if (m_mode == M_FLY) begin
            if (escape) m_mode = M_ESC;
            else if (tick) begin
                m_y = m_y - 1;
                if (m_y <= 80) m_mode = M_ROAM;
            end
        end else if (m_mode == M_ROAM) begin
            if (isShot) begin
                m_mode = M_HIT; m_cnt = 0;
            end else if (escape) begin
                m_mode = M_ESC;
            end else if (tick) begin
                nx = m_x + (m_dx != 0 ? 1 : -1);
                if (nx < 0 || nx > 146) m_dx = 1 - m_dx; else m_x = nx;
                ny = m_y + (m_up != 0 ? -1 : 1);
                if (ny < 8 || ny > 80) m_up = 1 - m_up; else m_y = ny;
            end
        end else if (m_mode == M_HIT) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == 16) m_mode = M_FALL;
            end
        end else if (m_mode == M_FALL) begin
            if (tick) begin
                m_y = (m_y + 2 > 100) ? 100 : m_y + 2;
                if (m_y == 100) begin m_down = 1; m_mode = M_IDLE; end
            end
        end else begin
            if (tick) begin
                if (m_y == 0) begin m_gone = 1; m_mode = M_IDLE; end
                else m_y = m_y - 1;
            end
        end
        fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
    endtask

    task automatic compare_all();
        check("x",        int'(XBird),    m_x);
        check("y",        int'(YBird),    m_y);
        check("fly",      int'(fly),      int'(m_mode == M_FLY || m_mode == M_ESC));
        check("fall",     int'(fall),     int'(m_mode == M_HIT || m_mode == M_FALL));
        check("visible",  int'(visible),  int'(m_mode != M_IDLE));
        check("birdDown", int'(birdDown), m_down);
        check("birdGone", int'(birdGone), m_gone);
    endtask

    task automatic step(input logic rs, input logic st, input logic tk,
                        input logic sh, input logic es);
        reset = rs; start = st; tick = tk; isShot = sh; escape = es;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_until_lfsr(input logic [7:0] want);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            if (m_lfsr == want) begin found = 1; break; end
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        check("lfsr_reached", int'(found), 1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; tick = 1'b0; isShot = 1'b0; escape = 1'b0;
        m_mode = M_IDLE; m_x = 0; m_y = 100; m_dx = 0; m_up = 1; m_cnt = 0;
        m_lfsr = 8'hA5; m_down = 0; m_gone = 0;

        // Reset state.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_x", int'(XBird), 0);
        check("rst_y", int'(YBird), 100);
        check("rst_visible", int'(visible), 0);

        // Spawn with lfsr=0xC8 and fly in.
        idle_until_lfsr(8'hC8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("spawn_x", int'(XBird), 8'h48);
        check("spawn_y", int'(YBird), 100);
        check("spawn_fly", int'(fly), 1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flyin_y", int'(YBird), 80);
        check("flyin_fly", int'(fly), 0);
        check("flyin_visible", int'(visible), 1);

        // Random roaming, then simultaneous shot/escape.
        for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("shot_wins_fall", int'(fall), 1);
        check("shot_wins_fly", int'(fly), 0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("hit_done_fall", int'(fall), 1);
        pulses = 0;
        for (int i = 0; i < 60 && visible; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(birdDown);
        end
        check("down_pulses", pulses, 1);
        check("down_y", int'(YBird), 100);
        check("down_visible", int'(visible), 0);

        // Right-edge bounce: spawn at X=145 heading right.
        idle_until_lfsr(8'h91);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("edge_x146", int'(XBird), 146);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bounce_hold", int'(XBird), 146);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("bounce_left", int'(XBird), 145);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("roam_reset_visible", int'(visible), 0);

        // FLY_IN ignores shots; escape climbs off the top.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flyin_y90", int'(YBird), 90);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flyin_shot_fly", int'(fly), 1);
        check("flyin_shot_fall", int'(fall), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("escape_fly", int'(fly), 1);
        for (int i = 0; i < 90; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("escape_y0", int'(YBird), 0);
        check("escape_visible", int'(visible), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("gone_pulse", int'(birdGone), 1);
        check("gone_visible", int'(visible), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("gone_once", int'(birdGone), 0);

        // Reset while falling.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midfall_fall", int'(fall), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("midfall_rst_y", int'(YBird), 100);
        check("midfall_rst_down", int'(birdDown), 0);
        check("midfall_rst_visible", int'(visible), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 299) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 79) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 start  input  1  level; request a new bird while in IDLE.
REQ-004 tick  input  1  one-cycle frame-rate enable; all motion advances only on cycles with tick=1.
REQ-005 isShot  input  1  hit report from the firing datapath.
REQ-006 escape  input  1  out-of-shots report from the firing datapath.
REQ-007 XBird  output  8  bird top-left X, in pixels.
REQ-008 YBird  output  8  bird top-left Y, in pixels.
REQ-009 fly  output  1  high in FLY_IN and ESCAPE; the bird cannot be hit while it is high.
REQ-010 fall  output  1  high in HIT and FALL.
REQ-011 visible  output  1  high in every state except IDLE.
REQ-012 birdDown  output  1  one-cycle pulse when a falling bird reaches the ground.
REQ-013 birdGone  output  1  one-cycle pulse when an escaping bird leaves the top of the screen.

Function
REQ-014 Constants: GROUND_Y=100, ROAM_TOP=8, ROAM_BOTTOM=80, X_MAX=146 (160 minus the hitbox width of 14), HIT_TICKS=16.
REQ-015 The block SHALL implement these states: IDLE, FLY_IN, ROAM, HIT, FALL, ESCAPE.
REQ-016 IDLE: when start=1, the next state SHALL be FLY_IN, with XBird=spawnX, YBird=GROUND_Y, dirX=lfsr[0] (1=right) and dirY=up; this transition SHALL NOT wait for tick.
REQ-017 spawnX SHALL be lfsr-128 when lfsr>X_MAX, otherwise lfsr.
REQ-018 FLY_IN: on each tick, YBird SHALL decrease by 1; on the tick where the new value is <=ROAM_BOTTOM, the next state SHALL be ROAM.
REQ-019 ROAM: on each tick, X and Y SHALL each move 1 pixel in their current direction.
REQ-020 ROAM bounce: a direction SHALL reverse instead of moving when the next position would leave [0,X_MAX] or [ROAM_TOP,ROAM_BOTTOM]; the edge is compared before the update, so no 8-bit wrap can occur.
REQ-021 ROAM: isShot=1 SHALL move to HIT, clear the hit counter and freeze position; this is evaluated every cycle, independent of tick.
REQ-022 ROAM: escape=1 SHALL move to ESCAPE.
REQ-023 If isShot and escape are both high in ROAM in the same cycle, isShot SHALL win.
REQ-024 FLY_IN: escape=1 SHALL move to ESCAPE; isShot SHALL be ignored.
REQ-025 HIT: the counter SHALL increment on each tick; when it reaches HIT_TICKS the next state SHALL be FALL, and position SHALL hold throughout HIT.
REQ-026 FALL: on each tick, YBird SHALL increase by 2, saturating at GROUND_Y; on reaching GROUND_Y, birdDown SHALL pulse and the next state SHALL be IDLE.
REQ-027 ESCAPE: on each tick, YBird SHALL decrease by 1 while X holds; when YBird==0 on a tick, birdGone SHALL pulse and the next state SHALL be IDLE.
REQ-028 In all non-IDLE states, start SHALL be ignored.
REQ-029 isShot and escape SHALL be ignored in HIT, FALL, ESCAPE and IDLE.
REQ-030 The LFSR SHALL be 8-bit, polynomial x^8+x^6+x^5+x^4+1, advancing every clk cycle.
REQ-031 The LFSR SHALL never hold 0.
REQ-032 Outputs SHALL be registered; fly, fall and visible SHALL be decoded from the registered state.

Reset
REQ-033 With reset=1, on the next edge: state=IDLE, XBird=0, YBird=GROUND_Y, dirX=0, dirY=up, hit counter=0, lfsr=8'hA5, fly=fall=visible=birdDown=birdGone=0.
REQ-034 Reset SHALL override every input and SHALL take effect from any state, including mid-fall or mid-escape; no pulse SHALL be emitted as a result of reset.

Structure
REQ-035 A shared package duck_pkg SHALL hold the screen constants, the hitbox size (14x9), HIT_TICKS and the motion-state enum.
REQ-036 The LFSR SHALL be a separate sub-module, bird_lfsr (clk, reset, value[7:0]).

Verification
REQ-037 Reset, then start=1 with lfsr=0xC8 -> XBird=0x48 (0xC8-128), YBird=100, fly=1; after 20 ticks YBird=80 and state=ROAM, fly=0.
REQ-038 ROAM at X=146 with dirX=right, then tick -> X stays 146 and dirX=left; the following tick gives X=145.
REQ-039 ROAM, isShot=1 and escape=1 in the same cycle -> HIT, fall=1; 16 ticks later FALL; from Y=60, 20 ticks give Y=100 and a single birdDown pulse, then IDLE.
REQ-040 FLY_IN with isShot=1 -> no state change; escape=1 -> ESCAPE; from Y=90, 90 ticks give Y=0, then birdGone pulses once and visible=0.
REQ-041 reset asserted in FALL at Y=70 -> next cycle IDLE, YBird=100, birdDown stays 0.
